axis_slice_fifo: RTL

Parametrised AXI-Stream buffer that generalises the single-entry register slice to a `DEPTH`-entry FIFO with configurable data width and a synchronous flush.

- Sits between pipeline stages, e.g. fetch → decode or LSU → bus, wherever more than one beat of elasticity is needed.
- Both handshake directions are fully registered, so no combinational path runs from `mif.tready` to `sif.tready`.
- Sustains one beat per cycle.
- `invalidate` discards all buffered beats, for pipeline flush on branch mispredict or trap.

---
 rtl/axis_pkg.sv | 16 +
 rtl/axis_if.sv | 23 ++
 rtl/axis_slice_fifo_mem.sv | 47 ++++
 rtl/axis_slice_fifo.sv | 111 +++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared helpers for the AXI-Stream buffer blocks: depth legality check and
// pointer width derivation.
package axis_pkg;

   // True when value is a positive power of two.
   function automatic bit is_pow2(int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

   // Pointer width for a circular buffer of the given depth: address bits plus
   // one wrap bit, so full and empty can be told apart.
   function automatic int ptr_width(int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream handshake bundle. sif is the receiving side (valid/data in,
// ready out); mif is the sending side (valid/data out, ready in).
interface axis_if #(
   parameter int TDATA_WIDTH = 32
) ();

   logic                   tvalid;
   logic                   tready;
   logic [TDATA_WIDTH-1:0] tdata;

   modport sif (
      input  tvalid,
      input  tdata,
      output tready
   );

   modport mif (
      output tvalid,
      output tdata,
      input  tready
   );

endinterface

// File: rtl/axis_slice_fifo_mem.sv
// DEPTH x TDATA_WIDTH storage with one write port and one registered read
// port. The array itself has no reset so it can map onto RAM.
module axis_slice_fifo_mem #(
   parameter int TDATA_WIDTH = 32,
   parameter int DEPTH       = 2,
   parameter int ADDR_W      = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [TDATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]      rd_addr,
   output logic [TDATA_WIDTH-1:0] rd_data
);

   logic [TDATA_WIDTH-1:0] mem [DEPTH];
   logic [TDATA_WIDTH-1:0] rd_data_q, rd_data_d;

   // Write-first read: a beat written into the slot that becomes the head on
   // this same edge must appear immediately (push into an empty buffer).
   always_comb begin
      rd_data_d = mem[rd_addr];
      if (wr_en && (wr_addr == rd_addr)) begin
         rd_data_d = wr_data;
      end
   end

   // Array write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read port; only this output register is reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_slice_fifo.sv
// DEPTH-entry AXI-Stream FIFO with fully registered handshakes and a
// synchronous invalidate that drops every stored beat.
// Optional occupancy output enabled by defining AXIS_SLICE_FIFO_LEVEL_EN.
import axis_pkg::*;

module axis_slice_fifo #(
   parameter int TDATA_WIDTH = 32,
   parameter int DEPTH       = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   axis_if.sif                        axis_sif,
   axis_if.mif                        axis_mif,
`ifdef AXIS_SLICE_FIFO_LEVEL_EN
   output logic [$clog2(DEPTH+1)-1:0] level,
`endif
   input  logic                       invalidate
);

   localparam int PTR_W  = ptr_width(DEPTH);
   localparam int ADDR_W = PTR_W - 1;

   if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
      $error("axis_slice_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic                   sif_tready_q, sif_tready_d;
   logic                   mif_tvalid_q, mif_tvalid_d;
   logic                   push, pop, wr_en;
   logic [TDATA_WIDTH-1:0] head_data;

   // Next pointers and flags. Invalidate wins over push and pop: the read
   // pointer jumps to the write pointer, so a beat being popped this cycle is
   // still delivered and a beat being pushed is dropped.
   always_comb begin
      push         = axis_sif.tvalid && sif_tready_q;
      pop          = mif_tvalid_q && axis_mif.tready;
      wr_en        = push && !invalidate;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      if (invalidate) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      mif_tvalid_d = (rd_ptr_d != wr_ptr_d);
      sif_tready_d = !((rd_ptr_d[ADDR_W-1:0] == wr_ptr_d[ADDR_W-1:0]) &&
                       (rd_ptr_d[ADDR_W] != wr_ptr_d[ADDR_W]));
   end

   // Pointer and handshake flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         sif_tready_q <= 1'b0;
         mif_tvalid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         sif_tready_q <= sif_tready_d;
         mif_tvalid_q <= mif_tvalid_d;
      end
   end

   // The read port tracks the next-state head, so its output register always
   // holds the entry at the current read pointer.
   axis_slice_fifo_mem #(
      .TDATA_WIDTH (TDATA_WIDTH),
      .DEPTH       (DEPTH),
      .ADDR_W      (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q[ADDR_W-1:0]),
      .wr_data (axis_sif.tdata),
      .rd_addr (rd_ptr_d[ADDR_W-1:0]),
      .rd_data (head_data)
   );

   assign axis_sif.tready = sif_tready_q;
   assign axis_mif.tvalid = mif_tvalid_q;
   assign axis_mif.tdata  = head_data;

`ifdef AXIS_SLICE_FIFO_LEVEL_EN
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic [LVL_W-1:0] level_q, level_d;

   // Occupancy follows the next-state pointer distance.
   always_comb begin
      level_d = LVL_W'(wr_ptr_d - rd_ptr_d);
   end

   // Occupancy register, updated on the same edge as the pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   assign level = level_q;
`endif

endmodule
